ahb_lite_sram_slave: RTL

- AHB-Lite slave with a byte-addressable SRAM behind it. This is the DUT that the AHB-Lite master VIP driver stimulates and the VIP monitor samples.
- Decodes address phases and inserts a programmable number of wait states.
- Performs byte, halfword and word writes and reads.
- Returns the two-cycle ERROR response for illegal accesses and for accesses the VIP flags via its error-injection pin.

---
 rtl/ahb_lite_pkg.sv | 48 ++++
 rtl/ahb_sram_mem.sv | 29 ++
 rtl/ahb_lite_sram_slave.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared encodings, controller state type and access-decode helpers for the
// AHB-Lite SRAM slave.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Little-endian lane select: lane k carries bits [8k+7:8k].
  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic access_ok(input logic [2:0] size, input logic [1:0] addr_lo,
                                     input logic in_range, input logic err_inj);
    logic aligned;
    case (size)
      HSIZE_BYTE: aligned = 1'b1;
      HSIZE_HALF: aligned = ~addr_lo[0];
      HSIZE_WORD: aligned = (addr_lo == 2'b00);
      default:    aligned = 1'b0;
    endcase
    return aligned & in_range & ~err_inj;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM: synchronous byte-enabled write, asynchronous read.
// Contents are deliberately not reset so data survives a bus reset.
module ahb_sram_mem #(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic            hclk,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   wdata,
  input  logic [IW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge hclk) begin
    if (we) begin
      for (int k = 0; k < DW/8; k++) begin
        if (be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting a byte-addressable SRAM with programmable OKAY wait
// states and the two-cycle ERROR response.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready; completes a pending zero-wait data phase, accepts next
// ST_WAIT | inserting wait states for a legal transfer (hready low)
// ST_ERR1 | first ERROR cycle (hready low, hresp high)
// ST_ERR2 | second ERROR cycle (hready high, hresp high), accepts next
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RW          = 1,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [1:0]    htrans,
  input  logic          hmastlock,
  input  logic          error,
  input  logic [DW-1:0] hwdata,
  output logic          hready,
  output logic [RW-1:0] hresp,
  output logic [DW-1:0] hrdata
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH * DW / 8);

  state_t state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;

  logic          dp_valid;
  logic          dp_write;
  logic [IW-1:0] dp_index;
  logic [3:0]    dp_be;

  logic          accept;
  logic          legal;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          unused_inputs;

  assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0], haddr[AW-1:IW+2]};

  assign hready = (state == ST_IDLE) || (state == ST_ERR2);
  assign hresp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? RW'(HRESP_ERROR) : RW'(HRESP_OKAY);
  assign accept = hsel & hready & htrans[1];
  assign legal  = access_ok(hsize, haddr[1:0], (haddr < ADDR_LIMIT), error);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (!legal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 4'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_index <= '0;
      dp_be    <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      // An errored transfer never opens a data phase, so it cannot write.
      if (hready) begin
        dp_valid <= accept & legal;
        if (accept) begin
          dp_write <= hwrite;
          dp_index <= haddr[IW+1:2];
          dp_be    <= byte_enable(hsize, haddr[1:0]);
        end
      end
    end
  end

  assign mem_we = dp_valid & dp_write & hready;

  ahb_sram_mem #(.DEPTH(DEPTH), .DW(DW)) u_mem (
    .hclk  (hclk),
    .we    (mem_we),
    .waddr (dp_index),
    .be    (dp_be),
    .wdata (hwdata),
    .raddr (dp_index),
    .rdata (mem_rdata)
  );

  assign hrdata = (dp_valid && !dp_write) ? mem_rdata : '0;

endmodule
